// File: rtl/reaction_display.sv
// Saturating binary-to-BCD converter (iterative double-dabble) feeding a
// time-multiplexed 4-digit seven-segment display with optional leading-zero blanking.
module reaction_display #(
  parameter int SCAN_DIV      = 10,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] value,
  output logic        busy,
  output logic        valid,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  // state | meaning
  // IDLE  | waiting for load; scan shows stored digits
  // SHIFT | one add-3/shift iteration per cycle, 14 total
  // DONE  | publish work register to bcd/ovf, pulse valid
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  state_t      state, state_nxt;
  logic [29:0] work;
  logic [3:0]  iter;
  logic        ovf_pend;
  logic [15:0] adj;
  logic        over;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic [6:0]    seg_raw;
  logic          blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign over = (value > 32'd9999);
  assign adj  = {add3(work[29:26]), add3(work[25:22]),
                 add3(work[21:18]), add3(work[17:14])};
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (iter == 4'd13) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work     <= '0;
      iter     <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= (state == DONE);
      case (state)
        IDLE: begin
          if (load) begin
            work     <= {16'b0, (over ? 14'd9999 : value[13:0])};
            iter     <= '0;
            ovf_pend <= over;
          end
        end
        SHIFT: begin
          // add-3 correction precedes the shift within the same iteration
          work <= {adj[14:0], work[13:0], 1'b0};
          iter <= iter + 4'd1;
        end
        DONE: begin
          bcd <= work[29:14];
          ovf <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign an = 4'b0001 << idx;

  always_comb begin
    nib   = bcd[3:0];
    blank = 1'b0;
    case (idx)
      2'd0: nib = bcd[3:0];
      2'd1: begin nib = bcd[7:4];   blank = (bcd[15:4] == 12'd0); end
      2'd2: begin nib = bcd[11:8];  blank = (bcd[15:8] == 8'd0);  end
      2'd3: begin nib = bcd[15:12]; blank = (bcd[15:12] == 4'd0); end
      default: ;
    endcase
  end

  always_comb begin
    seg_raw = 7'b0000000;
    case (nib)
      4'd0: seg_raw = 7'b0111111;
      4'd1: seg_raw = 7'b0000110;
      4'd2: seg_raw = 7'b1011011;
      4'd3: seg_raw = 7'b1001111;
      4'd4: seg_raw = 7'b1100110;
      4'd5: seg_raw = 7'b1101101;
      4'd6: seg_raw = 7'b1111101;
      4'd7: seg_raw = 7'b0000111;
      4'd8: seg_raw = 7'b1111111;
      4'd9: seg_raw = 7'b1101111;
      default: seg_raw = 7'b0000000;
    endcase
  end

  assign seg = (BLANK_LEADING && blank) ? 7'b0000000 : seg_raw;

endmodule
